// File: rtl/tt_smsdac_core.sv
// tt_smsdac_core
// 16-element, tree-structured, first-order mismatch-shaping unit-element DAC
// encoder. A 5-bit code is saturated to 0..16 and split through a binary tree
// of 15 switching blocks in 4 layers. Each odd split is steered up or down by
// a small per-block state so element usage is balanced over time.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst_n    - asynchronous active-low reset
//   ena      - design-selected flag (ignored)
//   ui_in    - [4:0] code x, [5] shape_en, [6] dither_en, [7] unused
//   uio_in   - unused
//   uo_out   - unit-element drive e[7:0]   (registered)
//   uio_out  - unit-element drive e[15:8]  (registered)
//   uio_oe   - constant 8'hFF, all bidirectional pins are outputs
module tt_smsdac_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int NBLK = 15;           // switching blocks
    localparam int NCNT = 2 * NBLK + 1; // block inputs plus 16 leaf counts

    // Switching state per block, two's complement: 2'b01=+1, 2'b00=0, 2'b11=-1
    logic [1:0]  q_r      [0:NBLK-1];
    logic [1:0]  q_next_s [0:NBLK-1];
    logic [4:0]  cnt_s    [0:NCNT-1];
    logic [15:0] lfsr_r;
    logic [15:0] e_r;
    logic [15:0] e_next_s;
    logic [14:0] rnd_s;
    logic [4:0]  xc_s;
    logic        lfsr_fb_s;
    logic        shape_en_s;
    logic        unused_s;

    // Switching value for one block: 0 on even counts; on odd counts steer
    // against the stored imbalance, using the random bit only when balanced.
    function automatic logic [1:0] switch_val(input logic [4:0] c,
                                              input logic [1:0] q,
                                              input logic       r,
                                              input logic       shape_en);
        logic [1:0] s;
        s = 2'b00;
        if (c[0] == 1'b0) begin
            s = 2'b00;
        end else if (shape_en == 1'b0) begin
            s = 2'b01;
        end else if (q == 2'b01) begin
            s = 2'b11;
        end else if (q[1] == 1'b1) begin
            s = 2'b01;
        end else if (r == 1'b1) begin
            s = 2'b01;
        end else begin
            s = 2'b11;
        end
        return s;
    endfunction

    assign shape_en_s = ui_in[5];
    assign xc_s       = (ui_in[4:0] > 5'd16) ? 5'd16 : ui_in[4:0];
    assign rnd_s      = ui_in[6] ? lfsr_r[14:0] : 15'h7FFF;
    // Taps 16,14,13,11 -> bits 15,13,12,10, shifting toward the MSB
    assign lfsr_fb_s  = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    assign unused_s   = ^{ena, uio_in, ui_in[7]};

    // Tree split: block k feeds 2k+1 (lower-index half) and 2k+2 (upper half);
    // entries NBLK..NCNT-1 are the per-element counts (0 or 1).
    always_comb begin
        logic [1:0] sw_v;
        logic [4:0] sum_v;
        sw_v  = 2'b00;
        sum_v = 5'd0;
        for (int i = 0; i < NCNT; i++) begin
            cnt_s[i] = 5'd0;
        end
        for (int k = 0; k < NBLK; k++) begin
            q_next_s[k] = q_r[k];
        end
        e_next_s = 16'h0000;
        cnt_s[0] = xc_s;
        for (int k = 0; k < NBLK; k++) begin
            sw_v  = switch_val(cnt_s[k], q_r[k], rnd_s[k], shape_en_s);
            // c+s is even whenever s is nonzero, so the shift is exact
            sum_v = cnt_s[k] + {{3{sw_v[1]}}, sw_v};
            cnt_s[2*k+1] = {1'b0, sum_v[4:1]};
            cnt_s[2*k+2] = cnt_s[k] - {1'b0, sum_v[4:1]};
            if (shape_en_s && cnt_s[k][0]) begin
                q_next_s[k] = q_r[k] + sw_v;
            end else begin
                q_next_s[k] = q_r[k];
            end
        end
        for (int j = 0; j < 16; j++) begin
            e_next_s[j] = cnt_s[NBLK+j][0];
        end
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= 16'hACE1;
            e_r    <= 16'h0000;
            for (int k = 0; k < NBLK; k++) begin
                q_r[k] <= 2'b00;
            end
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
            e_r    <= e_next_s;
            for (int k = 0; k < NBLK; k++) begin
                q_r[k] <= q_next_s[k];
            end
        end
    end

    assign uo_out  = e_r[7:0];
    assign uio_out = e_r[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_smsdac_core.sv
module tb_tt_smsdac_core;
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          mq [15];
    logic [15:0] mlfsr;
    logic [15:0] exp_e;
    int          exp_pop;

    typedef struct {
        logic [7:0] ui;
        logic [7:0] uo;
        logic [7:0] uio;
    } vec_t;
    vec_t tbl [10];

    logic [7:0]  stim [24];
    logic [15:0] rec  [24];

    tt_smsdac_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) mq[i] = 0;
        mlfsr   = 16'hACE1;
        exp_e   = 16'h0000;
        exp_pop = 0;
    endtask

    // One clock of the encoder: split counts layer by layer over element ranges
    task automatic model_step(input logic [7:0] ui);
        int cnt [15];
        int x, s, k, w, lo, top;
        x = int'(ui[4:0]);
        if (x > 16) x = 16;
        exp_pop = x;
        exp_e   = 16'h0000;
        cnt[0]  = x;
        for (int layer = 0; layer < 4; layer++) begin
            for (int i = 0; i < (1 << layer); i++) begin
                k  = (1 << layer) - 1 + i;
                w  = 16 >> layer;
                lo = i * w;
                s  = 0;
                if (cnt[k] % 2 != 0) begin
                    if (ui[5] == 1'b0) begin
                        s = 1;
                    end else begin
                        if (mq[k] > 0) s = -1;
                        else if (mq[k] < 0) s = 1;
                        else if (ui[6] == 1'b0 || mlfsr[k] == 1'b1) s = 1;
                        else s = -1;
                        mq[k] += s;
                    end
                end
                top = (cnt[k] + s) / 2;
                if (layer < 3) begin
                    cnt[2*k+1] = top;
                    cnt[2*k+2] = cnt[k] - top;
                end else begin
                    exp_e[lo]   = (top != 0);
                    exp_e[lo+1] = ((cnt[k] - top) != 0);
                end
            end
        end
        mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    endtask

    // Drive a code, let it be sampled, then compare at the falling edge
    task automatic apply(input logic [7:0] ui, output logic [15:0] got);
        ui_in = ui;
        @(posedge clk);
        model_step(ui);
        @(negedge clk);
        got = {uio_out, uo_out};
        chk("model_e", got, exp_e);
        chk("popcount", $countones(got), exp_pop);
    endtask

    // Asynchronous reset pulse entirely between two rising edges
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        ui_in = 8'($urandom);
        #1;
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hFF);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] got;
        int nz_lo, nz_hi;

        tbl[0] = '{8'h0F, 8'hFF, 8'h7F};
        tbl[1] = '{8'h01, 8'h01, 8'h00};
        tbl[2] = '{8'h00, 8'h00, 8'h00};
        tbl[3] = '{8'h05, 8'h15, 8'h11};
        tbl[4] = '{8'h08, 8'h55, 8'h55};
        tbl[5] = '{8'h02, 8'h01, 8'h01};
        tbl[6] = '{8'h50, 8'hFF, 8'hFF};
        tbl[7] = '{8'h70, 8'hFF, 8'hFF};
        tbl[8] = '{8'h7F, 8'hFF, 8'hFF};
        tbl[9] = '{8'h94, 8'hFF, 8'hFF};

        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h5A;
        ui_in  = 8'hFF;
        model_reset();
        #1;
        chk("pu_uo", uo_out, 8'h00);
        chk("pu_uio", uio_out, 8'h00);
        chk("pu_oe", uio_oe, 8'hFF);
        ui_in = 8'h70;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pu_clk_uo", uo_out, 8'h00);
        chk("pu_clk_uio", uio_out, 8'h00);
        rst_n = 1'b1;

        // Reference sequence after power-up, replayed after a mid-run reset
        for (int i = 0; i < 24; i++) begin
            stim[i] = 8'($urandom);
            apply(stim[i], got);
            rec[i] = got;
        end

        // Fixed-mapping and full-scale vectors
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].ui, got);
            chk("tbl_uo", got[7:0], tbl[i].uo);
            chk("tbl_uio", got[15:8], tbl[i].uio);
        end

        // Shaping with x=1: the root alternates halves within each cycle pair
        do_reset();
        nz_lo = 0;
        nz_hi = 0;
        for (int i = 0; i < 40; i++) begin
            apply(8'h61, got);
            if (got[7:0] != 8'h00) nz_lo++;
            if (got[15:8] != 8'h00) nz_hi++;
        end
        chk("shape_lo_cycles", nz_lo, 20);
        chk("shape_hi_cycles", nz_hi, 20);

        // Random sweep with a mid-run reset and replay
        for (int i = 0; i < 10000; i++) begin
            apply(8'($urandom), got);
            if (i == 5000) begin
                do_reset();
                for (int j = 0; j < 24; j++) begin
                    apply(stim[j], got);
                    chk("replay", got, rec[j]);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
